core_fetch_ctrl: RTL

//  Per-core sequencer for the program counter and its fetch/execute cycle.

---
 rtl/fetch_ctrl_pkg.sv | 24 ++
 rtl/core_fetch_ctrl_sat_counter.sv | 37 +++
 rtl/core_fetch_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the per-core fetch controller: FSM state
// encoding and the decoded instruction-class codes.
package fetch_ctrl_pkg;

   // Controller states. STEP_WAIT is reachable only in single-step builds.
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_LOAD      = 4'd1,
      ST_FETCH     = 4'd2,
      ST_DECODE    = 4'd3,
      ST_EXEC      = 4'd4,
      ST_MEMW      = 4'd5,
      ST_UPDATE    = 4'd6,
      ST_HALTED    = 4'd7,
      ST_STEP_WAIT = 4'd8
   } state_e;

   // Decoded instruction classes as presented on op_class.
   localparam logic [1:0] OP_ALU  = 2'b00;
   localparam logic [1:0] OP_MEM  = 2'b01;
   localparam logic [1:0] OP_BR   = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

endpackage

// File: rtl/core_fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the
// retired-instruction count. Clear has priority over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear wins, otherwise increment unless already all-ones.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/core_fetch_ctrl.sv
// Per-core program-counter sequencer: runs the fetch / decode / execute /
// update cycle, drives the PC load controls, handshakes with instruction
// and data memory and counts retired instructions.
// Optional single-step mode: define FETCH_CTRL_STEP_EN to add the step
// input and the STEP_WAIT state between UPDATE and the next FETCH.
//
// Handshakes: imem_req/dmem_req are levels held from state entry until
// the matching ack is seen in a cycle with core_en=1; an ack in any other
// cycle (request low, or core frozen) has no effect.
module core_fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W    = 6,
   parameter int CNT_W     = 16,
   parameter int RESET_VEC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              core_en,
`ifdef FETCH_CTRL_STEP_EN
   input  logic              step,
`endif
   output logic              imem_req,
   input  logic              imem_ack,
   output logic              ir_we,
   input  logic [1:0]        op_class,
   input  logic              branch_cond,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              dmem_req,
   input  logic              dmem_ack,
   output logic [ADDR_W-1:0] pc_gamma,
   output logic              pc_sel,
   output logic              pc_we,
   output logic              pc_en,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  instr_count,
   output logic [3:0]        dbg_state_o
);

   state_e              state_q, state_d;
   logic [1:0]          op_q;
   logic [ADDR_W-1:0]   target_q;
   logic                cond_q;
   logic                latch_en;
   logic                cnt_inc;
   logic                cnt_clr;
   logic                pc_we_raw;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic plus Moore output decode; a frozen core holds state.
   always_comb begin
      state_d   = state_q;
      latch_en  = 1'b0;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      pc_sel    = 1'b0;
      pc_gamma  = '0;
      pc_we_raw = 1'b0;
      busy      = 1'b1;
      halted    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            pc_gamma  = ADDR_W'(RESET_VEC);
            pc_we_raw = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            latch_en = 1'b1;
            case (op_class)
               OP_ALU:  state_d = ST_EXEC;
               OP_MEM:  state_d = ST_MEMW;
               OP_BR:   state_d = ST_UPDATE;
               default: state_d = ST_HALTED;
            endcase
         end
         ST_EXEC: begin
            state_d = ST_UPDATE;
         end
         ST_MEMW: begin
            dmem_req = 1'b1;
            if (dmem_ack) state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            pc_we_raw = 1'b1;
            cnt_inc   = 1'b1;
            if ((op_q == OP_BR) && cond_q) begin
               pc_gamma = target_q;
            end else begin
               pc_sel = 1'b1;
            end
`ifdef FETCH_CTRL_STEP_EN
            state_d = ST_STEP_WAIT;
`else
            state_d = ST_FETCH;
`endif
         end
`ifdef FETCH_CTRL_STEP_EN
         ST_STEP_WAIT: begin
            if (step) state_d = ST_FETCH;
         end
`endif
         ST_HALTED: begin
            busy   = 1'b0;
            halted = 1'b1;
            if (start) state_d = ST_LOAD;
         end
         default: begin
            busy    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      if (!core_en) begin
         state_d  = state_q;
         latch_en = 1'b0;
         cnt_inc  = 1'b0;
         cnt_clr  = 1'b0;
      end
   end

   // Instruction fields captured in DECODE for use in UPDATE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OP_ALU;
         target_q <= '0;
         cond_q   <= 1'b0;
      end else if (latch_en) begin
         op_q     <= op_class;
         target_q <= jump_target;
         cond_q   <= branch_cond;
      end
   end

   // Strobes are suppressed while the core is frozen; ir_we follows the ack.
   assign pc_we       = pc_we_raw & core_en;
   assign ir_we       = (state_q == ST_FETCH) & imem_ack & core_en;
   assign pc_en       = core_en & rst_n;
   assign dbg_state_o = state_q;

   sat_counter #(.W(CNT_W)) u_instr_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (cnt_inc),
      .clr_i   (cnt_clr),
      .count_o (instr_count)
   );

endmodule
